prog_loader: RTL and testbench

- Sequences a built-in program image into the 16x8 program memory over the shared address/data bus.
- Replaces manual switch entry; sits beside the input/control logic and owns the bus only while granted.
- Writes all 16 words, optionally reads them back and compares, then releases the bus and reports done or error.
- Runs on the 50 MHz board clock.

---
 rtl/prog_loader.sv | 253 +++++++++++++++++++++++++
 tb/tb_prog_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: copies one of four built-in 16-byte images into the program
// memory over the shared bus, optionally reads it back, then releases the bus.
module prog_loader #(
    parameter int SETUP_CYCLES = 1,
    parameter int WE_CYCLES    = 2,
    parameter int HOLD_CYCLES  = 1,
    parameter int READ_LAT     = 1,
    parameter int VERIFY       = 1
) (
    input  logic       clk,
    input  logic       CLR,
    input  logic       start,
    input  logic [1:0] prog_sel,
    input  logic       run,
    input  logic       bus_gnt,
    input  logic [7:0] rd_data,
    output logic       bus_req,
    output logic       ld_oe,
    output logic [3:0] ld_addr,
    output logic [7:0] ld_data,
    output logic       nWE,
    output logic       nCE,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] err_addr
);

    localparam int MAX_AB  = (SETUP_CYCLES > WE_CYCLES) ? SETUP_CYCLES : WE_CYCLES;
    localparam int MAX_CD  = (HOLD_CYCLES > READ_LAT) ? HOLD_CYCLES : READ_LAT;
    localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    if (SETUP_CYCLES < 1 || WE_CYCLES < 1 || HOLD_CYCLES < 1 || READ_LAT < 1) begin : g_param_check
        $fatal(1, "prog_loader: SETUP_CYCLES, WE_CYCLES, HOLD_CYCLES and READ_LAT must all be >= 1");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_RD_ADDR,
        S_RD_CMP,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      addr_q, addr_d;
    logic [1:0]      prog_q, prog_d;
    logic            err_q, err_d;
    logic [3:0]      err_addr_q, err_addr_d;

    logic            bus_req_q, bus_req_d;
    logic            ld_oe_q, ld_oe_d;
    logic [7:0]      ld_data_q, ld_data_d;
    logic            nwe_q, nwe_d;
    logic            nce_q, nce_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    function automatic logic [7:0] rom_byte(input logic [1:0] p, input logic [3:0] a);
        logic [7:0] b;
        b = 8'h00;
        case (p)
            2'd0: begin
                case (a)
                    4'd0:  b = 8'h09;
                    4'd1:  b = 8'h1A;
                    4'd2:  b = 8'h1B;
                    4'd3:  b = 8'h2C;
                    4'd4:  b = 8'hE0;
                    4'd5:  b = 8'hF0;
                    4'd9:  b = 8'h10;
                    4'd10: b = 8'h14;
                    4'd11: b = 8'h18;
                    4'd12: b = 8'h20;
                    default: b = 8'h00;
                endcase
            end
            2'd1:    b = {a, a};
            2'd2:    b = a[0] ? 8'h5A : 8'hA5;
            default: b = (a == 4'd0) ? 8'hF0 : 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic is_last(input logic [CW-1:0] c, input int n);
        return c == CW'(n - 1);
    endfunction

    // Any state that owns the bus aborts to ERR the moment the grant goes away.
    function automatic logic owns_bus(input state_t s);
        return (s == S_SETUP) || (s == S_STROBE) || (s == S_HOLD) ||
               (s == S_RD_ADDR) || (s == S_RD_CMP);
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        prog_d     = prog_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start && !run) begin
                    state_d    = S_REQ;
                    prog_d     = prog_sel;
                    err_d      = 1'b0;
                    err_addr_d = 4'd0;
                    addr_d     = 4'd0;
                    cnt_d      = '0;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end
            end
            S_SETUP: begin
                if (is_last(cnt_q, SETUP_CYCLES)) begin
                    state_d = S_STROBE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STROBE: begin
                if (is_last(cnt_q, WE_CYCLES)) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (is_last(cnt_q, HOLD_CYCLES)) begin
                    cnt_d = '0;
                    if (addr_q == 4'd15) begin
                        if (VERIFY != 0) begin
                            state_d = S_RD_ADDR;
                            addr_d  = 4'd0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        state_d = S_SETUP;
                        addr_d  = addr_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RD_ADDR: begin
                if (is_last(cnt_q, READ_LAT)) begin
                    state_d = S_RD_CMP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RD_CMP: begin
                if (rd_data != rom_byte(prog_q, addr_q)) begin
                    state_d    = S_ERR;
                    err_d      = 1'b1;
                    err_addr_d = addr_q;
                end else if (addr_q == 4'd15) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD_ADDR;
                    addr_d  = addr_q + 4'd1;
                    cnt_d   = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (owns_bus(state_q) && !bus_gnt) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_addr_d = addr_q;
            addr_d     = addr_q;
            cnt_d      = '0;
        end
    end

    // Bus outputs are decoded from the next state and registered, so they
    // change on the same edge as the state and never glitch.
    always_comb begin
        bus_req_d = (state_d == S_REQ) || owns_bus(state_d);
        ld_oe_d   = owns_bus(state_d);
        nwe_d     = (state_d != S_STROBE);
        nce_d     = !((state_d == S_RD_ADDR) || (state_d == S_RD_CMP));
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        ld_data_d = 8'h00;
        if ((state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD)) begin
            ld_data_d = rom_byte(prog_d, addr_d);
        end
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= 4'd0;
            prog_q     <= 2'd0;
            err_q      <= 1'b0;
            err_addr_q <= 4'd0;
            bus_req_q  <= 1'b0;
            ld_oe_q    <= 1'b0;
            ld_data_q  <= 8'h00;
            nwe_q      <= 1'b1;
            nce_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            prog_q     <= prog_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            bus_req_q  <= bus_req_d;
            ld_oe_q    <= ld_oe_d;
            ld_data_q  <= ld_data_d;
            nwe_q      <= nwe_d;
            nce_q      <= nce_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus_req  = bus_req_q;
    assign ld_oe    = ld_oe_q;
    assign ld_addr  = addr_q;
    assign ld_data  = ld_data_q;
    assign nWE      = nwe_q;
    assign nCE      = nce_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a default-parameter instance with a bus/memory model
// and a second instance with stretched write timing and no verify pass.
module tb_prog_loader;

    localparam int EXP1 = 1 + 16 * (1 + 2 + 1) + 16 * (1 + 1);
    localparam int EXP2 = 1 + 16 * (2 + 3 + 2);
    localparam logic [7:0] SAP [16] = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hE0, 8'hF0, 8'h00, 8'h00,
                                        8'h00, 8'h10, 8'h14, 8'h18, 8'h20, 8'h00, 8'h00, 8'h00};

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       CLR = 1'b1;
    logic       start = 1'b0, start2 = 1'b0;
    logic [1:0] prog_sel = 2'd0;
    logic       run = 1'b0;
    logic       gnt = 1'b1;
    logic [7:0] rd_data1;

    logic       bus_req1, ld_oe1, nWE1, nCE1, busy1, done1, err1;
    logic [3:0] ld_addr1, err_addr1;
    logic [7:0] ld_data1;
    logic       bus_req2, ld_oe2, nWE2, nCE2, busy2, done2, err2;
    logic [3:0] ld_addr2, err_addr2;
    logic [7:0] ld_data2;

    prog_loader #(.SETUP_CYCLES(1), .WE_CYCLES(2), .HOLD_CYCLES(1), .READ_LAT(1), .VERIFY(1)) dut (
        .clk(clk), .CLR(CLR), .start(start), .prog_sel(prog_sel), .run(run), .bus_gnt(gnt),
        .rd_data(rd_data1), .bus_req(bus_req1), .ld_oe(ld_oe1), .ld_addr(ld_addr1),
        .ld_data(ld_data1), .nWE(nWE1), .nCE(nCE1), .busy(busy1), .done(done1),
        .err(err1), .err_addr(err_addr1)
    );

    prog_loader #(.SETUP_CYCLES(2), .WE_CYCLES(3), .HOLD_CYCLES(2), .READ_LAT(1), .VERIFY(0)) dut2 (
        .clk(clk), .CLR(CLR), .start(start2), .prog_sel(2'd2), .run(run), .bus_gnt(gnt),
        .rd_data(8'h00), .bus_req(bus_req2), .ld_oe(ld_oe2), .ld_addr(ld_addr2),
        .ld_data(ld_data2), .nWE(nWE2), .nCE(nCE2), .busy(busy2), .done(done2),
        .err(err2), .err_addr(err_addr2)
    );

    // Memory model: captures strobed writes, optionally returns a bad byte on read-back.
    logic [7:0] mem1 [16];
    logic [7:0] mem2 [16];
    logic       cor_en = 1'b0;
    logic [3:0] cor_a = 4'd0;
    logic [7:0] cor_val = 8'h00;
    assign rd_data1 = (cor_en && ld_addr1 == cor_a) ? cor_val : mem1[ld_addr1];

    int lens1 [$];
    int lens2 [$];
    int run1 = 0, run2 = 0, viol = 0, nce2_low = 0, done1_cnt = 0, done2_cnt = 0;
    int nvec = 0, nfail = 0;

    always @(negedge clk) begin
        if (!nWE1 && ld_oe1) begin
            mem1[ld_addr1] = ld_data1;
            run1++;
        end else if (run1 != 0) begin
            lens1.push_back(run1);
            run1 = 0;
        end
        if (!nWE2 && ld_oe2) begin
            mem2[ld_addr2] = ld_data2;
            run2++;
        end else if (run2 != 0) begin
            lens2.push_back(run2);
            run2 = 0;
        end
        if ((!nWE1 && (!ld_oe1 || !nCE1)) || (!nWE2 && (!ld_oe2 || !nCE2))) viol++;
        if (!nCE2) nce2_low++;
        if (done1) done1_cnt++;
        if (done2) done2_cnt++;
    end

    function automatic logic [7:0] exp_byte(input int p, input int a);
        case (p)
            0:       return SAP[a];
            1:       return 8'(a * 17);
            2:       return (a % 2 == 0) ? 8'hA5 : 8'h5A;
            default: return (a == 0) ? 8'hF0 : 8'h00;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_bus_req"}, int'(bus_req1), 0);
        chk({tag, "_ld_oe"}, int'(ld_oe1), 0);
        chk({tag, "_nWE"}, int'(nWE1), 1);
        chk({tag, "_nCE"}, int'(nCE1), 1);
        chk({tag, "_ld_addr"}, int'(ld_addr1), 0);
        chk({tag, "_ld_data"}, int'(ld_data1), 0);
        chk({tag, "_busy"}, int'(busy1), 0);
        chk({tag, "_done"}, int'(done1), 0);
        chk({tag, "_err"}, int'(err1), 0);
        chk({tag, "_err_addr"}, int'(err_addr1), 0);
    endtask

    // Outcome rules: grant loss beats a bad read-back; otherwise success.
    task automatic predict(input int ca, input logic [7:0] cv, input int p, input int da,
                           output bit ed, output bit ee, output int ea);
        ed = 1'b0; ee = 1'b0; ea = 0;
        if (da >= 0) begin
            ee = 1'b1; ea = da;
        end else if (ca >= 0 && cv != exp_byte(p, ca)) begin
            ee = 1'b1; ea = ca;
        end else begin
            ed = 1'b1;
        end
    endtask

    task automatic run_case(input int p, input int ca, input logic [7:0] cv, input int da,
                            input bit poke, input bit ed, input bit ee, input int ea, input int ecyc);
        int cyc, done_cyc, nimg;
        bit seen_done, seen_err;
        logic snap_nwe, snap_oe, snap_req;
        for (int i = 0; i < 16; i++) mem1[i] = 8'hEE;
        lens1.delete();
        done1_cnt = 0;
        cor_en = (ca >= 0);
        cor_a = 4'(ca);
        cor_val = cv;
        snap_nwe = 1'b0; snap_oe = 1'b1; snap_req = 1'b1;
        @(negedge clk);
        start = 1'b1;
        prog_sel = 2'(p);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        chk("req_next_cycle", int'({bus_req1, busy1, err1}), 3'b110);
        seen_done = 1'b0; seen_err = 1'b0; done_cyc = 0;
        while (!seen_done && !seen_err && cyc < 400) begin
            if (poke && cyc == 10) begin start = 1'b1; prog_sel = ~2'(p); end
            if (poke && cyc == 11) start = 1'b0;
            if (da >= 0 && gnt && !nWE1 && ld_addr1 == 4'(da)) gnt = 1'b0;
            @(negedge clk);
            cyc++;
            if (done1) begin seen_done = 1'b1; done_cyc = cyc; end
            if (err1) begin
                seen_err = 1'b1;
                snap_nwe = nWE1; snap_oe = ld_oe1; snap_req = bus_req1;
            end
        end
        gnt = 1'b1;
        start = 1'b0;
        if (!seen_done && !seen_err) begin
            nvec++; nfail++;
            $display("FAIL load_timeout: no done or err after %0d cycles (prog %0d)", cyc, p);
        end
        @(negedge clk);
        @(negedge clk);
        chk("released", int'({busy1, bus_req1, ld_oe1, nWE1, nCE1}), 5'b00011);
        chk("err_flag", int'(err1), int'(ee));
        chk("done_pulses", done1_cnt, int'(ed));
        if (ee) begin
            chk("err_addr", int'(err_addr1), ea);
            chk("err_edge_bus", int'({snap_nwe, snap_oe, snap_req}), 3'b100);
        end
        if (ed) chk("cycles_to_done", done_cyc, ecyc);
        nimg = (da >= 0) ? da : 16;
        for (int a = 0; a < nimg; a++) chk($sformatf("image_p%0d_a%0d", p, a), int'(mem1[a]), int'(exp_byte(p, a)));
        if (da < 0) begin
            chk("strobe_count", lens1.size(), 16);
            foreach (lens1[i]) chk("strobe_width", lens1[i], 2);
        end
        cor_en = 1'b0;
    endtask

    typedef struct {
        int         prog;
        int         ca;
        logic [7:0] cv;
        int         da;
        bit         poke;
        bit         ed;
        bit         ee;
        int         ea;
        int         ecyc;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int cyc;
        bit ed, ee;
        int ea, p, mode, a, ca, da;
        logic [7:0] cv;
        logic prev_nwe;

        tbl[0] = '{prog: 0, ca: -1, cv: 8'h00, da: -1, poke: 0, ed: 1, ee: 0, ea: 0, ecyc: EXP1};
        tbl[1] = '{prog: 1, ca: 7,  cv: 8'h00, da: -1, poke: 0, ed: 0, ee: 1, ea: 7, ecyc: 0};
        tbl[2] = '{prog: 2, ca: -1, cv: 8'h00, da: 4,  poke: 0, ed: 0, ee: 1, ea: 4, ecyc: 0};
        tbl[3] = '{prog: 3, ca: -1, cv: 8'h00, da: -1, poke: 1, ed: 1, ee: 0, ea: 0, ecyc: EXP1};
        tbl[4] = '{prog: 1, ca: -1, cv: 8'h00, da: 15, poke: 1, ed: 0, ee: 1, ea: 15, ecyc: 0};

        repeat (3) @(negedge clk);
        check_reset("reset");
        CLR = 1'b0;

        for (int i = 0; i < 5; i++)
            run_case(tbl[i].prog, tbl[i].ca, tbl[i].cv, tbl[i].da, tbl[i].poke,
                     tbl[i].ed, tbl[i].ee, tbl[i].ea, tbl[i].ecyc);

        // start while the CPU runs must be ignored
        run = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("run_blocks_start", int'({bus_req1, busy1}), 0);
            @(negedge clk);
        end
        run = 1'b0;

        // CLR in the HOLD phase of address 10
        @(negedge clk);
        start = 1'b1;
        prog_sel = 2'd1;
        @(negedge clk);
        start = 1'b0;
        prev_nwe = 1'b1;
        cyc = 0;
        while (!(ld_addr1 == 4'd10 && ld_oe1 && nWE1 && !prev_nwe) && cyc < 200) begin
            prev_nwe = nWE1;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) begin
            nvec++; nfail++;
            $display("FAIL hold10_timeout: HOLD of addr 10 not seen in %0d cycles", cyc);
        end
        CLR = 1'b1;
        @(negedge clk);
        check_reset("clr_mid_load");
        CLR = 1'b0;
        run_case(3, -1, 8'h00, -1, 0, 1, 0, 0, EXP1);

        for (int r = 0; r < 12; r++) begin
            p = $urandom_range(3);
            mode = $urandom_range(2);
            a = $urandom_range(15);
            ca = -1; da = -1; cv = 8'h00;
            if (mode == 1) begin ca = a; cv = ~exp_byte(p, a); end
            if (mode == 2) da = a;
            predict(ca, cv, p, da, ed, ee, ea);
            run_case(p, ca, cv, da, 1'($urandom_range(1)), ed, ee, ea, EXP1);
        end

        // stretched timing, no verify pass
        for (int i = 0; i < 16; i++) mem2[i] = 8'hEE;
        lens2.delete();
        done2_cnt = 0;
        nce2_low = 0;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("dut2_cycles_to_done", cyc, EXP2);
        @(negedge clk);
        @(negedge clk);
        chk("dut2_done_pulses", done2_cnt, 1);
        chk("dut2_idle", int'({busy2, bus_req2, err2}), 0);
        chk("dut2_nce_never_low", nce2_low, 0);
        chk("dut2_strobe_count", lens2.size(), 16);
        foreach (lens2[i]) chk("dut2_strobe_width", lens2[i], 3);
        for (int k = 0; k < 16; k++) chk($sformatf("dut2_image_a%0d", k), int'(mem2[k]), int'(exp_byte(2, k)));

        chk("bus_protocol", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
